// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - mode encodings shared by shift-register blocks and benches
package shift_reg_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SHL   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SHR   = 3'd2;
    localparam logic [MODE_W-1:0] MODE_ROL   = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ROR   = 3'd4;
    localparam logic [MODE_W-1:0] MODE_LOAD  = 3'd5;
    localparam logic [MODE_W-1:0] MODE_CLEAR = 3'd6;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear, saturating at LIMIT
module sat_counter #(
    parameter int LIMIT = 4,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         at_limit
);

    assign at_limit = (cnt == W'(LIMIT));

    // Clear wins over increment; increments at the limit are absorbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !at_limit) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register; scan chain under UNIV_SHIFT_REG_SCAN_EN
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]  d,
    input  logic              si_l,
    input  logic              si_r,
`ifdef UNIV_SHIFT_REG_SCAN_EN
    input  logic              scan_en,
    input  logic              scan_in,
    output logic              scan_out,
`endif
    output logic [WIDTH-1:0]  q,
    output logic              so_l,
    output logic              so_r,
    output logic [CNT_W-1:0]  cnt,
    output logic              flushed
);

    logic             scan_en_i;
    logic             scan_in_i;
    logic [WIDTH-1:0] q_next;
    logic             op_en;
    logic             cnt_clr;
    logic             cnt_inc;

`ifdef UNIV_SHIFT_REG_SCAN_EN
    assign scan_en_i = scan_en;
    assign scan_in_i = scan_in;
    assign scan_out  = q[WIDTH-1];
`else
    assign scan_en_i = 1'b0;
    assign scan_in_i = 1'b0;
`endif

    assign op_en = en && !scan_en_i;
    assign so_l  = q[WIDTH-1];
    assign so_r  = q[0];

    always_comb begin
        q_next  = q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        if (scan_en_i) begin
            q_next = {q[WIDTH-2:0], scan_in_i};
        end else if (en) begin
            case (mode)
                MODE_SHL: begin
                    q_next  = {q[WIDTH-2:0], si_l};
                    cnt_inc = 1'b1;
                end
                MODE_SHR: begin
                    q_next  = {si_r, q[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                end
                MODE_ROL:   q_next = {q[WIDTH-2:0], q[WIDTH-1]};
                MODE_ROR:   q_next = {q[0], q[WIDTH-1:1]};
                MODE_LOAD: begin
                    q_next  = d;
                    cnt_clr = 1'b1;
                end
                MODE_CLEAR: begin
                    q_next  = '0;
                    cnt_clr = 1'b1;
                end
                default:    q_next = q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_next;
        end
    end

    sat_counter #(
        .LIMIT (WIDTH),
        .W     (CNT_W)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr && op_en),
        .inc      (cnt_inc && op_en),
        .cnt      (cnt),
        .at_limit (flushed)
    );

endmodule
